// File: rtl/sha_256_arbiter.sv
// Two-requester round-robin front end for a single SHA-256 core.
// One 512-bit block is in flight at a time: accept, launch the core, wait for
// hash_ready (bounded by TIMEOUT), then hold the digest until the owner takes it.
module sha_256_arbiter #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TMR_W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         req_valid_0,
  input  logic         req_valid_1,
  input  logic [511:0] req_msg_0,
  input  logic [511:0] req_msg_1,
  output logic         req_ready_0,
  output logic         req_ready_1,

  output logic         resp_valid_0,
  output logic         resp_valid_1,
  input  logic         resp_ready_0,
  input  logic         resp_ready_1,
  output logic [255:0] resp_digest,
  output logic         resp_err,

  output logic [511:0] core_msg,
  output logic         core_start,
  input  logic         core_hash_ready,
  input  logic [255:0] core_result,

  output logic         busy
);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_e;

  localparam logic [TMR_W-1:0] TimeoutVal = TMR_W'(TIMEOUT);

  state_e             r_state;
  state_e             w_state_d;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_d;
  logic [TMR_W-1:0]   w_timer_inc;
  logic               r_grant;
  logic               w_grant_d;
  logic               r_last_grant;
  logic               w_last_grant_d;
  logic [511:0]       r_core_msg;
  logic [511:0]       w_core_msg_d;
  logic [255:0]       r_digest;
  logic [255:0]       w_digest_d;
  logic               r_err;
  logic               w_err_d;

  logic               w_idle;
  logic               w_sel;
  logic               w_accept;
  logic               w_resp_hs;

  assign w_idle      = (r_state == StIdle);
  assign w_timer_inc = r_timer + TMR_W'(1);

  // Round-robin pick: on a tie favour the requester not served last time.
  always_comb begin
    w_sel = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      w_sel = ~r_last_grant;
    end else if (req_valid_1) begin
      w_sel = 1'b1;
    end
  end

  // Request/response handshake decode; ready is only offered while idle.
  always_comb begin
    req_ready_0  = w_idle && req_valid_0 && !w_sel;
    req_ready_1  = w_idle && req_valid_1 && w_sel;
    w_accept     = req_ready_0 || req_ready_1;
    resp_valid_0 = (r_state == StResp) && !r_grant;
    resp_valid_1 = (r_state == StResp) && r_grant;
    // Only the granted requester's resp_ready can complete the response.
    w_resp_hs    = (r_state == StResp) && (r_grant ? resp_ready_1 : resp_ready_0);
    core_start   = (r_state == StLaunch);
    busy         = !w_idle;
  end

  // Next-state and datapath update for the launch/wait/respond sequence.
  always_comb begin
    w_state_d      = r_state;
    w_timer_d      = r_timer;
    w_grant_d      = r_grant;
    w_last_grant_d = r_last_grant;
    w_core_msg_d   = r_core_msg;
    w_digest_d     = r_digest;
    w_err_d        = r_err;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_core_msg_d   = w_sel ? req_msg_1 : req_msg_0;
          w_grant_d      = w_sel;
          w_last_grant_d = w_sel;
          w_state_d      = StLaunch;
        end
      end

      StLaunch: begin
        w_timer_d = '0;
        w_state_d = StWait;
      end

      StWait: begin
        // hash_ready has priority over a timeout landing in the same cycle.
        if (core_hash_ready) begin
          w_digest_d = core_result;
          w_err_d    = 1'b0;
          w_state_d  = StResp;
        end else begin
          w_timer_d = w_timer_inc;
          // >= keeps a degenerate TIMEOUT of 0 from wrapping the counter forever.
          if (w_timer_inc >= TimeoutVal) begin
            w_digest_d = '0;
            w_err_d    = 1'b1;
            w_state_d  = StResp;
          end
        end
      end

      StResp: begin
        if (w_resp_hs) begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_timer      <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_core_msg   <= '0;
      r_digest     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_timer      <= w_timer_d;
      r_grant      <= w_grant_d;
      r_last_grant <= w_last_grant_d;
      r_core_msg   <= w_core_msg_d;
      r_digest     <= w_digest_d;
      r_err        <= w_err_d;
    end
  end

  assign core_msg    = r_core_msg;
  assign resp_digest = r_digest;
  assign resp_err    = r_err;

endmodule
